// File: rtl/ahb_mem_slave_param.sv
// rtl/ahb_mem_slave_param.sv - parametrised AHB memory slave with wait states, range/size/alignment checks and split tracking
module ahb_mem_slave_param #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_BYTES = 2048,
  parameter int WAIT_STATES = 0,
  parameter int BIG_ENDIAN  = 0,
  parameter int SLA_ID      = 0,
  parameter int NUM_MASTERS = 2,
  parameter int SPLIT_EN    = 1,
  localparam int MST_W      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [15:0]            hsel_i,
  input  logic [ADDR_W-1:0]      haddr_i,
  input  logic [1:0]             htrans_i,
  input  logic                   hwrite_i,
  input  logic [2:0]             hsize_i,
  input  logic [DATA_W-1:0]      hwdata_i,
  input  logic [MST_W-1:0]       hmaster_i,
  input  logic                   hmastlock_i,
  input  logic                   hready_i,
  input  logic                   mem_busy_i,
  output logic                   hready_out_o,
  output logic [1:0]             hresp_o,
  output logic [DATA_W-1:0]      hrdata_o,
  output logic [NUM_MASTERS-1:0] hsplit_o
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int OFF_W  = $clog2(DEPTH_BYTES);
  localparam int IDX_W  = OFF_W - LANE_W;
  localparam int WORDS  = DEPTH_BYTES / NB;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [1:0] RESP_RETRY = 2'b10;
  localparam logic [1:0] RESP_SPLIT = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_RESP1, S_RESP2} state_t;

  state_t                 state_q;
  logic [3:0]             cnt_q;
  logic [IDX_W-1:0]       idx_q;
  logic [NB-1:0]          mask_q;
  logic                   wr_q;
  logic                   hready_out_q;
  logic [1:0]             hresp_q;
  logic [DATA_W-1:0]      hrdata_q;
  logic [NUM_MASTERS-1:0] pending_q;
  logic [DATA_W-1:0]      mem_q [WORDS];

  logic                   accept;
  logic [ADDR_W-1:0]      align_mask;
  logic [1:0]             resp_new;
  logic [IDX_W-1:0]       new_idx;
  logic [NB-1:0]          new_mask;
  logic [NB-1:0]          rd_mask;
  logic [IDX_W-1:0]       ridx;
  logic [DATA_W-1:0]      rword;
  logic [DATA_W-1:0]      rdata_new;
  logic                   release_now;
  logic [NUM_MASTERS-1:0] split_bits;
  logic [NUM_MASTERS-1:0] pending_d;
  logic                   unused_bits;

  assign unused_bits = ^{hsel_i, htrans_i[0]};

  // Lanes covered by a transfer of 2^size bytes starting at lane k of the word.
  function automatic logic [NB-1:0] lane_mask(input logic [LANE_W-1:0] k, input logic [2:0] size);
    logic [NB-1:0] m;
    int lo;
    int hi;
    m  = '0;
    lo = int'(k);
    hi = lo + (1 << size);
    for (int i = 0; i < NB; i++) begin
      if (i >= lo && i < hi) begin
        if (BIG_ENDIAN != 0) m[NB-1-i] = 1'b1;
        else                 m[i]      = 1'b1;
      end
    end
    return m;
  endfunction

  always_comb begin
    accept      = hsel_i[SLA_ID] && hready_i && htrans_i[1] &&
                  (state_q == S_IDLE || state_q == S_DONE);
    align_mask  = ~({ADDR_W{1'b1}} << hsize_i);
    resp_new    = RESP_OKAY;
    if ((haddr_i >> OFF_W) != '0)           resp_new = RESP_ERROR;
    else if (int'(hsize_i) > LANE_W)        resp_new = RESP_ERROR;
    else if ((haddr_i & align_mask) != '0)  resp_new = RESP_ERROR;
    else if (mem_busy_i)                    resp_new = ((SPLIT_EN != 0) && !hmastlock_i) ? RESP_SPLIT : RESP_RETRY;
    new_idx     = haddr_i[OFF_W-1:LANE_W];
    new_mask    = lane_mask(haddr_i[LANE_W-1:0], hsize_i);
    ridx        = accept ? new_idx : idx_q;
    rd_mask     = accept ? new_mask : mask_q;
    rword       = mem_q[ridx];
    // A write finishing this edge is not yet in mem_q; forward its lanes.
    if (state_q == S_DONE && wr_q && ridx == idx_q) begin
      for (int b = 0; b < NB; b++) begin
        if (mask_q[b]) rword[8*b +: 8] = hwdata_i[8*b +: 8];
      end
    end
    rdata_new = '0;
    for (int b = 0; b < NB; b++) begin
      if (rd_mask[b]) rdata_new[8*b +: 8] = rword[8*b +: 8];
    end
    release_now = !mem_busy_i && (pending_q != '0);
    split_bits  = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (accept && resp_new == RESP_SPLIT && int'(hmaster_i) == m) split_bits[m] = 1'b1;
    end
    pending_d = (release_now ? '0 : pending_q) | split_bits;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == S_DONE && wr_q) begin
      for (int b = 0; b < NB; b++) begin
        if (mask_q[b]) mem_q[idx_q][8*b +: 8] <= hwdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      mask_q       <= '0;
      wr_q         <= 1'b0;
      hready_out_q <= 1'b1;
      hresp_q      <= RESP_OKAY;
      hrdata_q     <= '0;
      pending_q    <= '0;
    end else begin
      pending_q <= pending_d;
      hrdata_q  <= '0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            idx_q  <= new_idx;
            mask_q <= new_mask;
            if (resp_new != RESP_OKAY) begin
              wr_q         <= 1'b0;
              state_q      <= S_RESP1;
              hready_out_q <= 1'b0;
              hresp_q      <= resp_new;
            end else if (WAIT_STATES > 0) begin
              wr_q         <= hwrite_i;
              state_q      <= S_WAIT;
              cnt_q        <= 4'(WAIT_STATES - 1);
              hready_out_q <= 1'b0;
              hresp_q      <= RESP_OKAY;
            end else begin
              wr_q         <= hwrite_i;
              state_q      <= S_DONE;
              hready_out_q <= 1'b1;
              hresp_q      <= RESP_OKAY;
              hrdata_q     <= hwrite_i ? '0 : rdata_new;
            end
          end else begin
            wr_q         <= 1'b0;
            state_q      <= S_IDLE;
            hready_out_q <= 1'b1;
            hresp_q      <= RESP_OKAY;
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_q      <= S_DONE;
            hready_out_q <= 1'b1;
            hrdata_q     <= wr_q ? '0 : rdata_new;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP1: begin
          state_q      <= S_RESP2;
          hready_out_q <= 1'b1;
        end
        S_RESP2: begin
          // Master must be IDLE here; anything sampled is dropped.
          state_q      <= S_IDLE;
          hready_out_q <= 1'b1;
          hresp_q      <= RESP_OKAY;
        end
        default: begin
          state_q      <= S_IDLE;
          hready_out_q <= 1'b1;
          hresp_q      <= RESP_OKAY;
        end
      endcase
    end
  end

  assign hready_out_o = hready_out_q;
  assign hresp_o      = hresp_q;
  assign hrdata_o     = hrdata_q;
  assign hsplit_o     = release_now ? pending_q : '0;

endmodule

// File: tb/tb_ahb_mem_slave_param.sv
// tb/tb_ahb_mem_slave_param.sv - directed bench for ahb_mem_slave_param (LE zero-wait slot and BE three-wait slot)
module tb_ahb_mem_slave_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hmaster;
  logic        hmastlock;
  logic        mem_busy;
  logic        hready;

  logic        rdy_a, rdy_b;
  logic [1:0]  resp_a, resp_b;
  logic [31:0] rdata_a, rdata_b;
  logic [1:0]  hsplit_a, hsplit_b;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;
  assign hready = rdy_a & rdy_b;

  ahb_mem_slave_param #(
    .DATA_W(32), .ADDR_W(32), .DEPTH_BYTES(2048), .WAIT_STATES(0),
    .BIG_ENDIAN(0), .SLA_ID(0), .NUM_MASTERS(2), .SPLIT_EN(1)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .hsel_i(hsel), .haddr_i(haddr), .htrans_i(htrans),
    .hwrite_i(hwrite), .hsize_i(hsize), .hwdata_i(hwdata), .hmaster_i(hmaster),
    .hmastlock_i(hmastlock), .hready_i(hready), .mem_busy_i(mem_busy),
    .hready_out_o(rdy_a), .hresp_o(resp_a), .hrdata_o(rdata_a), .hsplit_o(hsplit_a)
  );

  ahb_mem_slave_param #(
    .DATA_W(32), .ADDR_W(32), .DEPTH_BYTES(2048), .WAIT_STATES(3),
    .BIG_ENDIAN(1), .SLA_ID(1), .NUM_MASTERS(2), .SPLIT_EN(1)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .hsel_i(hsel), .haddr_i(haddr), .htrans_i(htrans),
    .hwrite_i(hwrite), .hsize_i(hsize), .hwdata_i(hwdata), .hmaster_i(hmaster),
    .hmastlock_i(hmastlock), .hready_i(hready), .mem_busy_i(mem_busy),
    .hready_out_o(rdy_b), .hresp_o(resp_b), .hrdata_o(rdata_b), .hsplit_o(hsplit_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Address phase, then data phase; returns with the slave in its final data cycle.
  task automatic xfer(input int slv, input logic wr, input logic [31:0] addr, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd, output int waits);
    hsel   = (slv == 0) ? 16'h0001 : 16'h0002;
    haddr  = addr;
    htrans = 2'b10;
    hwrite = wr;
    hsize  = sz;
    step();
    htrans = 2'b00;
    hwdata = wd;
    waits  = 0;
    while (((slv == 0) ? rdy_a : rdy_b) == 1'b0 && waits < 20) begin
      check("wait_rdata_zero", (slv == 0) ? rdata_a : rdata_b, 0);
      waits++;
      step();
    end
    rd = (slv == 0) ? rdata_a : rdata_b;
  endtask

  task automatic err_seq_a(input string tag, input logic wr, input logic [31:0] addr, input logic [2:0] sz);
    hsel   = 16'h0001;
    haddr  = addr;
    htrans = 2'b10;
    hwrite = wr;
    hsize  = sz;
    step();
    check({tag, "_c1_resp"}, resp_a, 2'b01);
    check({tag, "_c1_rdy"}, rdy_a, 0);
    htrans = 2'b00;
    hwdata = 32'hFFFF_FFFF;
    step();
    check({tag, "_c2_resp"}, resp_a, 2'b01);
    check({tag, "_c2_rdy"}, rdy_a, 1);
    check({tag, "_c2_rdata"}, rdata_a, 0);
    step();
    check({tag, "_after_resp"}, resp_a, 2'b00);
  endtask

  logic [31:0] rd;
  int          w;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; hsel = '0; haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2;
    hwdata = '0; hmaster = 1'b0; hmastlock = 1'b0; mem_busy = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_rdy_a", rdy_a, 1);
    check("rst_resp_a", resp_a, 0);
    check("rst_rdata_a", rdata_a, 0);
    check("rst_hsplit_a", hsplit_a, 0);
    check("rst_rdy_b", rdy_b, 1);
    step();
    rst = 1'b0;
    step();

    // Zero-wait LE slot: write then immediate read (forwarding path)
    xfer(0, 1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF, rd, w);
    check("a_wr_waits", w, 0);
    xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, rd, w);
    check("a_rd_data", rd, 32'hDEAD_BEEF);
    check("a_rd_waits", w, 0);
    check("a_rd_resp", resp_a, 0);
    step();
    check("a_rdata_idle", rdata_a, 0);

    xfer(0, 1'b1, 32'h20, 3'd2, 32'h1234_5678, rd, w);
    xfer(0, 1'b1, 32'h22, 3'd1, 32'hBEEF_9999, rd, w);
    xfer(0, 1'b0, 32'h21, 3'd0, 32'h0, rd, w);
    check("a_byte21", rd, 32'h0000_5600);
    xfer(0, 1'b0, 32'h20, 3'd2, 32'h0, rd, w);
    check("a_word20_merged", rd, 32'hBEEF_5678);
    xfer(0, 1'b1, 32'h7FC, 3'd2, 32'h0BAD_CAFE, rd, w);
    check("a_last_wr_resp", resp_a, 0);
    xfer(0, 1'b0, 32'h7FC, 3'd2, 32'h0, rd, w);
    check("a_last_rd", rd, 32'h0BAD_CAFE);

    err_seq_a("a_range", 1'b0, 32'h800, 3'd2);
    err_seq_a("a_misalign", 1'b1, 32'h21, 3'd1);
    err_seq_a("a_size", 1'b1, 32'h20, 3'd3);
    xfer(0, 1'b0, 32'h20, 3'd2, 32'h0, rd, w);
    check("a_mem_unchanged", rd, 32'hBEEF_5678);
    step();

    // SPLIT from master 1, then release
    hmaster = 1'b1; mem_busy = 1'b1;
    hsel = 16'h0001; haddr = 32'h10; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2;
    step();
    check("split_c1_resp", resp_a, 2'b11);
    check("split_c1_rdy", rdy_a, 0);
    check("split_c1_hsplit", hsplit_a, 0);
    htrans = 2'b00;
    step();
    check("split_c2_resp", resp_a, 2'b11);
    check("split_c2_rdy", rdy_a, 1);
    step();
    check("split_busy_hsplit", hsplit_a, 0);
    mem_busy = 1'b0;
    #1;
    check("split_release", hsplit_a, 2'b10);
    step();
    check("split_release_once", hsplit_a, 0);

    // Locked transfer while busy: RETRY, no split release
    hmaster = 1'b0; hmastlock = 1'b1; mem_busy = 1'b1;
    htrans = 2'b10;
    step();
    check("retry_c1_resp", resp_a, 2'b10);
    check("retry_c1_rdy", rdy_a, 0);
    htrans = 2'b00;
    step();
    check("retry_c2_resp", resp_a, 2'b10);
    check("retry_c2_rdy", rdy_a, 1);
    mem_busy = 1'b0; hmastlock = 1'b0;
    #1;
    check("retry_no_hsplit", hsplit_a, 0);
    step();
    check("retry_no_hsplit_later", hsplit_a, 0);

    // Three-wait BE slot
    xfer(1, 1'b1, 32'h10, 3'd2, 32'h0102_0304, rd, w);
    check("b_wr_waits", w, 3);
    xfer(1, 1'b0, 32'h11, 3'd0, 32'h0, rd, w);
    check("b_byte11", rd, 32'h0002_0000);
    check("b_rd_waits", w, 3);
    xfer(1, 1'b0, 32'h13, 3'd0, 32'h0, rd, w);
    check("b_byte13", rd, 32'h0000_0004);
    xfer(1, 1'b1, 32'h11, 3'd0, 32'h11AB_2233, rd, w);
    xfer(1, 1'b0, 32'h11, 3'd0, 32'h0, rd, w);
    check("b_byte11_new", rd, 32'h00AB_0000);
    xfer(1, 1'b0, 32'h10, 3'd2, 32'h0, rd, w);
    check("b_word10", rd, 32'h01AB_0304);
    xfer(1, 1'b1, 32'h14, 3'd2, 32'hCAFE_F00D, rd, w);
    step();

    // Reset in the middle of a write's wait states
    hsel = 16'h0002; haddr = 32'h14; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    step();
    htrans = 2'b00; hwdata = 32'h0;
    step();
    check("b_mid_wait_rdy", rdy_b, 0);
    rst = 1'b1;
    #1;
    check("b_rst_rdy", rdy_b, 1);
    check("b_rst_resp", resp_b, 0);
    check("b_rst_rdata", rdata_b, 0);
    check("b_rst_hsplit", hsplit_b, 0);
    step();
    rst = 1'b0;
    step();
    xfer(1, 1'b0, 32'h14, 3'd2, 32'h0, rd, w);
    check("b_write_dropped", rd, 32'hCAFE_F00D);
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
